// File: rtl/swerv_types_pkg.sv
// swerv_types: shared retire-trace packet types
package swerv_types;
   typedef struct packed {
      logic        valid;
      logic        exception;
      logic        interrupt;
      logic [31:0] insn;
      logic [31:0] address;
   } trace_lane_t;
   typedef struct packed {
      logic [4:0]  ecause;
      logic [31:0] tval;
      logic        ovf;
   } trace_hdr_t;
   localparam int LANE_W = $bits(trace_lane_t);
   localparam int HDR_W  = $bits(trace_hdr_t);
endpackage

// File: rtl/trace_fifo_mem.sv
// trace_fifo_mem: flop array with one write port and one asynchronous read port
module trace_fifo_mem #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/swerv_trace_fifo.sv
// swerv_trace_fifo: retire-trace packet buffer with drop/backpressure overflow handling
module swerv_trace_fifo
   import swerv_types::*;
#(
   parameter int NUM_LANES  = 3,
   parameter int DEPTH      = 8,
   parameter int STALL_MODE = 0,
   parameter int CNT_W      = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_LANES-1:0]      in_valid_ip,
   input  logic [32*NUM_LANES-1:0]   in_insn_ip,
   input  logic [32*NUM_LANES-1:0]   in_address_ip,
   input  logic [NUM_LANES-1:0]      in_exception_ip,
   input  logic [NUM_LANES-1:0]      in_interrupt_ip,
   input  logic [4:0]                in_ecause_ip,
   input  logic [31:0]               in_tval_ip,
   output logic                      in_ready,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [NUM_LANES-1:0]      out_valid_ip,
   output logic [32*NUM_LANES-1:0]   out_insn_ip,
   output logic [32*NUM_LANES-1:0]   out_address_ip,
   output logic [NUM_LANES-1:0]      out_exception_ip,
   output logic [NUM_LANES-1:0]      out_interrupt_ip,
   output logic [4:0]                out_ecause_ip,
   output logic [31:0]               out_tval_ip,
   output logic                      out_ovf,
   input  logic                      flush,
   input  logic                      clr_drop_cnt,
   output logic [CNT_W-1:0]          drop_cnt,
   output logic [$clog2(DEPTH):0]    level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int EW = HDR_W + NUM_LANES * LANE_W;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] lvl;
   logic          ovf_pending;
   logic [EW-1:0] wdata, rdata, rd;
   logic          push_req, full, accept, drop, pop;
   trace_hdr_t    hdr;
   trace_lane_t   lane;
   assign push_req  = |in_valid_ip;
   assign full      = lvl == FULL_LVL;
   assign in_ready  = (STALL_MODE != 0) ? !full : 1'b1;
   assign out_valid = lvl != '0;
   assign accept    = push_req && !full && !flush;
   assign drop      = (STALL_MODE == 0) && push_req && full && !flush;
   assign pop       = out_valid && out_ready && !flush;
   assign level     = lvl;
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         lvl         <= '0;
         ovf_pending <= 1'b0;
         drop_cnt    <= '0;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            lvl    <= '0;
            if (out_valid || push_req) ovf_pending <= 1'b1;
         end else begin
            wr_ptr <= wr_ptr + AW'(accept);
            rd_ptr <= rd_ptr + AW'(pop);
            lvl    <= lvl + LW'(accept) - LW'(pop);
            ovf_pending <= drop ? 1'b1 : accept ? 1'b0 : ovf_pending;
         end
         if (clr_drop_cnt) drop_cnt <= CNT_W'(drop);
         else if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
   end
   always_comb begin
      wdata = '0;
      wdata[EW-1 -: HDR_W] = {in_ecause_ip, in_tval_ip, ovf_pending};
      for (int i = 0; i < NUM_LANES; i++)
         wdata[i*LANE_W +: LANE_W] = {in_valid_ip[i], in_exception_ip[i], in_interrupt_ip[i],
                                      in_insn_ip[i*32 +: 32], in_address_ip[i*32 +: 32]};
   end
   trace_fifo_mem #(.WIDTH(EW), .DEPTH(DEPTH)) u_mem (
      .clk   (clk),
      .we    (accept),
      .waddr (wr_ptr),
      .wdata (wdata),
      .raddr (rd_ptr),
      .rdata (rdata)
   );
   // empty FIFO presents an all-zero packet rather than stale array contents
   always_comb begin
      rd               = out_valid ? rdata : '0;
      hdr              = trace_hdr_t'(rd[EW-1 -: HDR_W]);
      out_ecause_ip    = hdr.ecause;
      out_tval_ip      = hdr.tval;
      out_ovf          = hdr.ovf;
      lane             = '0;
      out_valid_ip     = '0;
      out_exception_ip = '0;
      out_interrupt_ip = '0;
      out_insn_ip      = '0;
      out_address_ip   = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         lane                   = trace_lane_t'(rd[i*LANE_W +: LANE_W]);
         out_valid_ip[i]        = lane.valid;
         out_exception_ip[i]    = lane.exception;
         out_interrupt_ip[i]    = lane.interrupt;
         out_insn_ip[i*32 +: 32]    = lane.insn;
         out_address_ip[i*32 +: 32] = lane.address;
      end
   end
endmodule

// File: tb/tb_swerv_trace_fifo.sv
// tb_swerv_trace_fifo: directed checks of drop mode (dut0) and backpressure mode (dut1)
module tb_swerv_trace_fifo;
   logic        clk = 0, rst = 0, flush = 0, clr = 0, rdy0 = 0, rdy1 = 0;
   logic [2:0]  vld = 0, exc = 0, intr = 0;
   logic [95:0] insn = 0, addr = 0;
   logic [4:0]  ecause = 0;
   logic [31:0] tval = 0;
   logic        in_ready0, out_valid0, out_ovf0, in_ready1, out_valid1, out_ovf1;
   logic [2:0]  ov0, oe0, oi0, ov1, oe1, oi1;
   logic [95:0] oin0, oad0, oin1, oad1;
   logic [4:0]  oec0, oec1;
   logic [31:0] otv0, otv1;
   logic [3:0]  dc0;
   logic [15:0] dc1;
   logic [3:0]  lvl0, lvl1;
   int errors = 0, checks = 0;
   always #5 clk = ~clk;
   swerv_trace_fifo #(.NUM_LANES(3), .DEPTH(8), .STALL_MODE(0), .CNT_W(4)) dut0 (
      .clk(clk), .rst(rst), .in_valid_ip(vld), .in_insn_ip(insn), .in_address_ip(addr),
      .in_exception_ip(exc), .in_interrupt_ip(intr), .in_ecause_ip(ecause), .in_tval_ip(tval),
      .in_ready(in_ready0), .out_valid(out_valid0), .out_ready(rdy0), .out_valid_ip(ov0),
      .out_insn_ip(oin0), .out_address_ip(oad0), .out_exception_ip(oe0), .out_interrupt_ip(oi0),
      .out_ecause_ip(oec0), .out_tval_ip(otv0), .out_ovf(out_ovf0), .flush(flush),
      .clr_drop_cnt(clr), .drop_cnt(dc0), .level(lvl0));
   swerv_trace_fifo #(.NUM_LANES(3), .DEPTH(8), .STALL_MODE(1), .CNT_W(16)) dut1 (
      .clk(clk), .rst(rst), .in_valid_ip(vld), .in_insn_ip(insn), .in_address_ip(addr),
      .in_exception_ip(exc), .in_interrupt_ip(intr), .in_ecause_ip(ecause), .in_tval_ip(tval),
      .in_ready(in_ready1), .out_valid(out_valid1), .out_ready(rdy1), .out_valid_ip(ov1),
      .out_insn_ip(oin1), .out_address_ip(oad1), .out_exception_ip(oe1), .out_interrupt_ip(oi1),
      .out_ecause_ip(oec1), .out_tval_ip(otv1), .out_ovf(out_ovf1), .flush(1'b0),
      .clr_drop_cnt(1'b0), .drop_cnt(dc1), .level(lvl1));
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic set_pkt(input logic [31:0] a);
      vld  = 3'b001;
      addr = {64'h0, a};
      insn = {64'h0, a ^ 32'h13};
      exc  = 0;
      intr = 0;
   endtask
   initial begin
      rst = 1;
      tick();
      tick();
      rst = 0;
      chk("rst_level", lvl0, 0);
      chk("rst_out_valid", out_valid0, 0);
      chk("rst_drop_cnt", dc0, 0);
      chk("rst_in_ready0", in_ready0, 1);
      chk("rst_in_ready1", in_ready1, 1);
      chk("rst_out_ovf", out_ovf0, 0);
      vld = 3'b101; exc = 3'b100; intr = 3'b001;
      insn = {32'hdeadbeef, 32'h0, 32'h00000013};
      addr = {32'h80000004, 32'h0, 32'h80000000};
      ecause = 5'h3; tval = 32'h1234;
      tick();
      vld = 0;
      chk("single_valid", out_valid0, 1);
      chk("single_valid_ip", ov0, 3'b101);
      chk("single_insn", oin0, {32'hdeadbeef, 32'h0, 32'h00000013});
      chk("single_addr", oad0, {32'h80000004, 32'h0, 32'h80000000});
      chk("single_exc", oe0, 3'b100);
      chk("single_intr", oi0, 3'b001);
      chk("single_ecause", oec0, 5'h3);
      chk("single_tval", otv0, 32'h1234);
      chk("single_ovf", out_ovf0, 0);
      chk("single_level", lvl0, 1);
      rdy0 = 1;
      tick();
      rdy0 = 0;
      chk("pop_level", lvl0, 0);
      chk("pop_valid", out_valid0, 0);
      chk("pop_insn_zero", oin0, 0);
      chk("pop_addr_zero", oad0, 0);
      chk("pop_tval_zero", otv0, 0);
      for (int i = 0; i < 10; i++) begin
         set_pkt(i);
         tick();
      end
      vld = 0;
      chk("ovf_level_full", lvl0, 8);
      chk("ovf_drop_cnt", dc0, 2);
      chk("ovf_in_ready_mode0", in_ready0, 1);
      rdy0 = 1;
      for (int i = 0; i < 8; i++) begin
         chk("drain_valid", out_valid0, 1);
         chk("drain_addr", oad0[31:0], i);
         chk("drain_ovf", out_ovf0, 0);
         tick();
      end
      rdy0 = 0;
      chk("drain_empty", lvl0, 0);
      set_pkt(100);
      tick();
      chk("after_drop_ovf", out_ovf0, 1);
      set_pkt(101);
      tick();
      vld = 0;
      chk("two_level", lvl0, 2);
      rdy0 = 1;
      tick();
      chk("next_addr", oad0[31:0], 101);
      chk("next_ovf", out_ovf0, 0);
      tick();
      chk("next_empty", lvl0, 0);
      set_pkt(200);
      tick();
      for (int i = 1; i <= 24; i++) begin
         set_pkt(200 + i);
         tick();
         chk("stream_addr", oad0[31:0], 200 + i);
         chk("stream_level", lvl0, 1);
      end
      vld = 0;
      tick();
      rdy0 = 0;
      chk("stream_empty", lvl0, 0);
      chk("stream_drop_cnt", dc0, 2);
      for (int i = 0; i < 5; i++) begin
         set_pkt(300 + i);
         tick();
      end
      chk("pre_flush_level", lvl0, 5);
      set_pkt(305);
      flush = 1;
      tick();
      flush = 0;
      vld = 0;
      chk("flush_level", lvl0, 0);
      chk("flush_valid", out_valid0, 0);
      chk("flush_drop_cnt", dc0, 2);
      set_pkt(400);
      tick();
      vld = 0;
      chk("post_flush_addr", oad0[31:0], 400);
      chk("post_flush_ovf", out_ovf0, 1);
      rdy0 = 1;
      tick();
      rdy0 = 0;
      chk("post_flush_empty", lvl0, 0);
      for (int i = 0; i < 28; i++) begin
         set_pkt(i);
         tick();
      end
      chk("sat_drop_cnt", dc0, 4'hf);
      chk("sat_level", lvl0, 8);
      clr = 1;
      tick();
      clr = 0;
      vld = 0;
      chk("clr_with_drop", dc0, 1);
      clr = 1;
      tick();
      clr = 0;
      chk("clr_alone", dc0, 0);
      rdy0 = 1;
      for (int i = 0; i < 5; i++) tick();
      rdy0 = 0;
      chk("pre_rst_level", lvl0, 3);
      rst = 1;
      tick();
      rst = 0;
      chk("midrst_level", lvl0, 0);
      chk("midrst_valid", out_valid0, 0);
      set_pkt(500);
      tick();
      vld = 0;
      chk("midrst_ovf_cleared", out_ovf0, 0);
      rst = 1;
      tick();
      rst = 0;
      for (int i = 0; i < 8; i++) begin
         set_pkt(600 + i);
         tick();
      end
      chk("m1_level_full", lvl1, 8);
      chk("m1_in_ready_full", in_ready1, 0);
      set_pkt(608);
      rdy1 = 1;
      chk("m1_in_ready_same_cycle", in_ready1, 0);
      tick();
      rdy1 = 0;
      chk("m1_rejected_level", lvl1, 7);
      chk("m1_in_ready_next", in_ready1, 1);
      tick();
      vld = 0;
      chk("m1_held_accepted", lvl1, 8);
      chk("m1_in_ready_refull", in_ready1, 0);
      rdy1 = 1;
      for (int i = 1; i <= 8; i++) begin
         chk("m1_order", oad1[31:0], 600 + i);
         tick();
      end
      rdy1 = 0;
      chk("m1_empty", lvl1, 0);
      chk("m1_no_drops", dc1, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
